// File: rtl/ula_pkg.sv
// ula_pkg: shared opcodes, FSM state encoding and default widths for the
// ula_seq operation sequencer and its timeout counter.
package ula_pkg;

    localparam int unsigned LARG_A         = 16;
    localparam int unsigned LARG_B         = 8;
    localparam int unsigned TIMEOUT_PADRAO = 128;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        DISPARA = 2'd1,
        ESPERA  = 2'd2,
        CONCLUI = 2'd3
    } estado_t;

endpackage : ula_pkg

// File: rtl/ula_timeout.sv
// ula_timeout: cycle counter bounding how long the sequencer waits for a unit.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   limpa_i       clear the count (takes priority over habilita_i)
//   habilita_i    count one cycle
//   estouro_o     registered; high while the count equals TIMEOUT-1, i.e.
//                 during the TIMEOUT-th enabled cycle after a clear
module ula_timeout #(
    parameter int unsigned TIMEOUT = ula_pkg::TIMEOUT_PADRAO
) (
    input  logic clk,
    input  logic rst,
    input  logic limpa_i,
    input  logic habilita_i,
    output logic estouro_o
);

    localparam int unsigned LARG_CNT = $clog2(TIMEOUT + 1);

    logic [LARG_CNT-1:0] cnt_q, cnt_d;
    logic                estouro_q, estouro_d;

    // Flag is computed from the next count so it lines up with cnt_q.
    always_comb begin : cnt_comb
        cnt_d = cnt_q;
        if (limpa_i) begin
            cnt_d = '0;
        end else if (habilita_i) begin
            cnt_d = cnt_q + LARG_CNT'(1);
        end
        estouro_d = (cnt_d == LARG_CNT'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin : cnt_reg
        if (rst) begin
            cnt_q     <= '0;
            estouro_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            estouro_q <= estouro_d;
        end
    end

    assign estouro_o = estouro_q;

endmodule : ula_timeout

// File: rtl/ula_seq.sv
// ula_seq: sequencer in front of the 8-bit multiplier and divider. Latches one
// request, pulses the selected unit's start line, waits for its done flag and
// holds the result with pronto; flags div-by-zero and unit timeout via erro.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   inicio, op, a, b          request strobe, opcode (0 mul, 1 div), operands
//   resultado, resto          product/quotient and remainder (0 for mul)
//   pronto, erro, ocupado     result valid, error, busy (all registered)
//   mul_*                     multiplier handshake and operands
//   div_*                     divider handshake and operands
module ula_seq #(
    parameter int unsigned LARG_A  = ula_pkg::LARG_A,
    parameter int unsigned LARG_B  = ula_pkg::LARG_B,
    parameter int unsigned TIMEOUT = ula_pkg::TIMEOUT_PADRAO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inicio,
    input  logic              op,
    input  logic [LARG_A-1:0] a,
    input  logic [LARG_B-1:0] b,
    output logic [LARG_A-1:0] resultado,
    output logic [LARG_B-1:0] resto,
    output logic              pronto,
    output logic              ocupado,
    output logic              erro,
    output logic              mul_inicio,
    output logic [LARG_A-1:0] mul_multiplicando,
    output logic [LARG_B-1:0] mul_multiplicador,
    input  logic [LARG_A-1:0] mul_produto,
    input  logic              mul_fim,
    output logic              div_inicio,
    output logic [LARG_A-1:0] div_dividendo,
    output logic [LARG_B-1:0] div_divisor,
    input  logic [LARG_A-1:0] div_quociente,
    input  logic [LARG_B-1:0] div_resto,
    input  logic              div_fim
);

    import ula_pkg::*;

    estado_t estado_q, estado_d;

    logic              op_q, op_d;
    logic [LARG_A-1:0] a_q, a_d;
    logic [LARG_B-1:0] b_q, b_d;
    logic [LARG_A-1:0] resultado_q, resultado_d;
    logic [LARG_B-1:0] resto_q, resto_d;
    logic              pronto_q, pronto_d;
    logic              erro_q, erro_d;
    logic              ocupado_q, ocupado_d;
    logic              mul_inicio_q, mul_inicio_d;
    logic              div_inicio_q, div_inicio_d;
    logic              espera_inicial_q, espera_inicial_d;

    logic estouro;
    logic aceita_c, div_zero_c, fim_sel_c, fim_ok_c, estouro_ok_c;

    ula_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .limpa_i    (estado_q == DISPARA),
        .habilita_i (estado_q == ESPERA),
        .estouro_o  (estouro)
    );

    // Request decode and completion conditions shared by both comb processes.
    assign aceita_c     = inicio && ((estado_q == OCIOSO) || (estado_q == CONCLUI));
    assign div_zero_c   = (op == OP_DIV) && (b == '0);
    assign fim_sel_c    = (op_q == OP_DIV) ? div_fim : mul_fim;
    // First ESPERA cycle is masked so a done flag left over from the previous
    // operation cannot be taken as completion of this one.
    assign fim_ok_c     = (estado_q == ESPERA) && !espera_inicial_q && fim_sel_c;
    assign estouro_ok_c = (estado_q == ESPERA) && estouro;

    // State register.
    always_ff @(posedge clk) begin : estado_reg
        if (rst) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic.
    always_comb begin : prox_estado_comb
        estado_d = estado_q;
        case (estado_q)
            OCIOSO, CONCLUI: begin
                if (aceita_c) begin
                    estado_d = div_zero_c ? CONCLUI : DISPARA;
                end
            end
            DISPARA: estado_d = ESPERA;
            ESPERA: begin
                if (fim_ok_c || estouro_ok_c) begin
                    estado_d = CONCLUI;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // Output/datapath next values; every output is registered below.
    always_comb begin : saida_comb
        op_d             = op_q;
        a_d              = a_q;
        b_d              = b_q;
        resultado_d      = resultado_q;
        resto_d          = resto_q;
        pronto_d         = pronto_q;
        erro_d           = erro_q;
        ocupado_d        = 1'b0;
        mul_inicio_d     = 1'b0;
        div_inicio_d     = 1'b0;
        espera_inicial_d = (estado_q == DISPARA);
        case (estado_q)
            OCIOSO, CONCLUI: begin
                if (aceita_c) begin
                    op_d     = op;
                    a_d      = a;
                    b_d      = b;
                    pronto_d = 1'b0;
                    erro_d   = 1'b0;
                    if (div_zero_c) begin
                        pronto_d    = 1'b1;
                        erro_d      = 1'b1;
                        resultado_d = '0;
                        resto_d     = '0;
                    end else begin
                        ocupado_d    = 1'b1;
                        mul_inicio_d = (op == OP_MUL);
                        div_inicio_d = (op == OP_DIV);
                    end
                end
            end
            DISPARA: ocupado_d = 1'b1;
            ESPERA: begin
                // Done beats timeout when both happen in the same cycle.
                if (fim_ok_c) begin
                    pronto_d = 1'b1;
                    erro_d   = 1'b0;
                    if (op_q == OP_DIV) begin
                        resultado_d = div_quociente;
                        resto_d     = div_resto;
                    end else begin
                        resultado_d = mul_produto;
                        resto_d     = '0;
                    end
                end else if (estouro_ok_c) begin
                    pronto_d    = 1'b1;
                    erro_d      = 1'b1;
                    resultado_d = '0;
                    resto_d     = '0;
                end else begin
                    ocupado_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and operand registers.
    always_ff @(posedge clk) begin : saida_reg
        if (rst) begin
            op_q             <= 1'b0;
            a_q              <= '0;
            b_q              <= '0;
            resultado_q      <= '0;
            resto_q          <= '0;
            pronto_q         <= 1'b0;
            erro_q           <= 1'b0;
            ocupado_q        <= 1'b0;
            mul_inicio_q     <= 1'b0;
            div_inicio_q     <= 1'b0;
            espera_inicial_q <= 1'b0;
        end else begin
            op_q             <= op_d;
            a_q              <= a_d;
            b_q              <= b_d;
            resultado_q      <= resultado_d;
            resto_q          <= resto_d;
            pronto_q         <= pronto_d;
            erro_q           <= erro_d;
            ocupado_q        <= ocupado_d;
            mul_inicio_q     <= mul_inicio_d;
            div_inicio_q     <= div_inicio_d;
            espera_inicial_q <= espera_inicial_d;
        end
    end

    assign resultado         = resultado_q;
    assign resto             = resto_q;
    assign pronto            = pronto_q;
    assign erro              = erro_q;
    assign ocupado           = ocupado_q;
    assign mul_inicio        = mul_inicio_q;
    assign div_inicio        = div_inicio_q;
    assign mul_multiplicando = a_q;
    assign mul_multiplicador = b_q;
    assign div_dividendo     = a_q;
    assign div_divisor       = b_q;

endmodule : ula_seq

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed bench for ula_seq with behavioural multiplier and
// divider models. Both models react to the start pulse one cycle late, so the
// previous done flag is still visible during the first wait cycle.
module tb_ula_seq;

    logic        clk;
    logic        rst;
    logic        inicio;
    logic        op;
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] resultado;
    logic [7:0]  resto;
    logic        pronto;
    logic        ocupado;
    logic        erro;
    logic        mul_inicio;
    logic [15:0] mul_multiplicando;
    logic [7:0]  mul_multiplicador;
    logic [15:0] mul_produto;
    logic        mul_fim;
    logic        div_inicio;
    logic [15:0] div_dividendo;
    logic [7:0]  div_divisor;
    logic [15:0] div_quociente;
    logic [7:0]  div_resto;
    logic        div_fim;

    logic        mul_stuck;
    logic        ini_m, ini_d;
    logic [2:0]  cnt_m, cnt_dv;

    int checks = 0;
    int errors = 0;
    int n_mul  = 0;
    int n_div  = 0;
    int n_ocup = 0;

    ula_seq #(
        .LARG_A  (16),
        .LARG_B  (8),
        .TIMEOUT (128)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .inicio            (inicio),
        .op                (op),
        .a                 (a),
        .b                 (b),
        .resultado         (resultado),
        .resto             (resto),
        .pronto            (pronto),
        .ocupado           (ocupado),
        .erro              (erro),
        .mul_inicio        (mul_inicio),
        .mul_multiplicando (mul_multiplicando),
        .mul_multiplicador (mul_multiplicador),
        .mul_produto       (mul_produto),
        .mul_fim           (mul_fim),
        .div_inicio        (div_inicio),
        .div_dividendo     (div_dividendo),
        .div_divisor       (div_divisor),
        .div_quociente     (div_quociente),
        .div_resto         (div_resto),
        .div_fim           (div_fim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: done flag held high until the next start is seen.
    always @(posedge clk) begin
        if (rst) begin
            ini_m       <= 1'b0;
            cnt_m       <= 3'd0;
            mul_fim     <= 1'b0;
            mul_produto <= 16'd0;
        end else begin
            ini_m <= mul_inicio;
            if (ini_m) begin
                mul_fim <= 1'b0;
                cnt_m   <= 3'd3;
            end else if (cnt_m != 3'd0) begin
                cnt_m <= cnt_m - 3'd1;
                if (cnt_m == 3'd1 && !mul_stuck) begin
                    mul_fim     <= 1'b1;
                    mul_produto <= 16'(mul_multiplicando * {8'd0, mul_multiplicador});
                end
            end
        end
    end

    // Divider model, same handshake shape.
    always @(posedge clk) begin
        if (rst) begin
            ini_d         <= 1'b0;
            cnt_dv        <= 3'd0;
            div_fim       <= 1'b0;
            div_quociente <= 16'd0;
            div_resto     <= 8'd0;
        end else begin
            ini_d <= div_inicio;
            if (ini_d) begin
                div_fim <= 1'b0;
                cnt_dv  <= 3'd4;
            end else if (cnt_dv != 3'd0) begin
                cnt_dv <= cnt_dv - 3'd1;
                if (cnt_dv == 3'd1 && div_divisor != 8'd0) begin
                    div_fim       <= 1'b1;
                    div_quociente <= div_dividendo / {8'd0, div_divisor};
                    div_resto     <= 8'(div_dividendo % {8'd0, div_divisor});
                end
            end
        end
    end

    // Pulse/level counters sampled mid-cycle.
    always @(negedge clk) begin
        if (mul_inicio) n_mul  = n_mul + 1;
        if (div_inicio) n_div  = n_div + 1;
        if (ocupado)    n_ocup = n_ocup + 1;
    end

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks = checks + 1;
        if (obs !== esp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    task automatic ciclo;
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns just after the sampling edge.
    task automatic pede(input logic o, input logic [15:0] x, input logic [7:0] y);
        inicio = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        ciclo();
        inicio = 1'b0;
    endtask

    task automatic espera_pronto(input int lim);
        int k;
        k = 0;
        while (!pronto && k < lim) begin
            ciclo();
            k++;
        end
        verifica("espera_pronto", 32'(pronto), 1);
    endtask

    task automatic verifica_zerado(input string tag);
        verifica({tag, "_resultado"}, 32'(resultado), 0);
        verifica({tag, "_resto"}, 32'(resto), 0);
        verifica({tag, "_pronto"}, 32'(pronto), 0);
        verifica({tag, "_erro"}, 32'(erro), 0);
        verifica({tag, "_ocupado"}, 32'(ocupado), 0);
        verifica({tag, "_mul_inicio"}, 32'(mul_inicio), 0);
        verifica({tag, "_div_inicio"}, 32'(div_inicio), 0);
        verifica({tag, "_operandos"},
                 {mul_multiplicando, mul_multiplicador, div_divisor}, 0);
        verifica({tag, "_dividendo"}, 32'(div_dividendo), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        inicio    = 1'b0;
        op        = 1'b0;
        a         = 16'd0;
        b         = 8'd0;
        mul_stuck = 1'b0;
        ciclo();
        ciclo();
        verifica_zerado("reset");
        rst = 1'b0;
        ciclo();

        // Multiply 25 x 12
        n_mul = 0; n_div = 0;
        pede(1'b0, 16'd25, 8'd12);
        verifica("mul_pulso", 32'(mul_inicio), 1);
        verifica("mul_div_inicio", 32'(div_inicio), 0);
        verifica("mul_ocupado", 32'(ocupado), 1);
        verifica("mul_multiplicando", 32'(mul_multiplicando), 25);
        verifica("mul_multiplicador", 32'(mul_multiplicador), 12);
        espera_pronto(20);
        verifica("mul_resultado", 32'(resultado), 300);
        verifica("mul_resto", 32'(resto), 0);
        verifica("mul_erro", 32'(erro), 0);
        ciclo();
        ciclo();
        verifica("mul_pronto_mantido", 32'(pronto), 1);
        verifica("mul_n_pulsos", 32'(n_mul), 1);
        verifica("mul_n_div", 32'(n_div), 0);

        // Back-to-back 10 x 12 from CONCLUI, stale mul_fim still high
        n_mul = 0;
        pede(1'b0, 16'd10, 8'd12);
        verifica("b2b_pronto_cai", 32'(pronto), 0);
        verifica("b2b_pulso", 32'(mul_inicio), 1);
        ciclo();
        ciclo();
        verifica("b2b_fim_velho_ignorado", 32'(pronto), 0);
        verifica("b2b_ocupado", 32'(ocupado), 1);
        espera_pronto(20);
        verifica("b2b_resultado", 32'(resultado), 120);
        verifica("b2b_n_pulsos", 32'(n_mul), 1);

        // Divide by zero: 50 / 0
        n_div = 0; n_ocup = 0;
        pede(1'b1, 16'd50, 8'd0);
        verifica("dz_pronto", 32'(pronto), 1);
        verifica("dz_erro", 32'(erro), 1);
        verifica("dz_resultado", 32'(resultado), 0);
        verifica("dz_resto", 32'(resto), 0);
        verifica("dz_ocupado", 32'(ocupado), 0);
        verifica("dz_div_inicio", 32'(div_inicio), 0);
        verifica("dz_dividendo", 32'(div_dividendo), 50);
        ciclo();
        ciclo();
        ciclo();
        verifica("dz_pronto_mantido", 32'(pronto), 1);
        verifica("dz_n_div", 32'(n_div), 0);
        verifica("dz_n_ocupado", 32'(n_ocup), 0);

        // Divide 200 / 7
        n_mul = 0; n_div = 0;
        pede(1'b1, 16'd200, 8'd7);
        verifica("div_pulso", 32'(div_inicio), 1);
        verifica("div_mul_inicio", 32'(mul_inicio), 0);
        verifica("div_pronto_cai", 32'(pronto), 0);
        verifica("div_erro_cai", 32'(erro), 0);
        espera_pronto(20);
        verifica("div_resultado", 32'(resultado), 28);
        verifica("div_resto", 32'(resto), 4);
        verifica("div_erro", 32'(erro), 0);
        verifica("div_n_pulsos", 32'(n_div), 1);
        verifica("div_n_mul", 32'(n_mul), 0);

        // Timeout with a stuck multiplier; requests during ESPERA ignored
        mul_stuck = 1'b1;
        n_div = 0;
        pede(1'b0, 16'd3, 8'd5);
        for (int k = 1; k <= 128; k++) begin
            ciclo();
            if (k == 5) begin
                inicio = 1'b1;
                op     = 1'b1;
                a      = 16'd99;
                b      = 8'd0;
            end
            if (k == 6) begin
                inicio = 1'b0;
                verifica("to_multiplicando", 32'(mul_multiplicando), 3);
                verifica("to_multiplicador", 32'(mul_multiplicador), 5);
                verifica("to_ocupado", 32'(ocupado), 1);
                verifica("to_pronto_ignora", 32'(pronto), 0);
            end
        end
        verifica("to_antes_pronto", 32'(pronto), 0);
        verifica("to_antes_ocupado", 32'(ocupado), 1);
        ciclo();
        verifica("to_pronto", 32'(pronto), 1);
        verifica("to_erro", 32'(erro), 1);
        verifica("to_resultado", 32'(resultado), 0);
        verifica("to_ocupado_fim", 32'(ocupado), 0);
        verifica("to_n_div", 32'(n_div), 0);
        mul_stuck = 1'b0;

        // Reset in the middle of a multiply, then a clean 25 x 12
        pede(1'b0, 16'd25, 8'd12);
        ciclo();
        ciclo();
        n_mul = 0;
        rst   = 1'b1;
        ciclo();
        verifica_zerado("rst_meio");
        rst = 1'b0;
        ciclo();
        ciclo();
        ciclo();
        verifica("rst_sem_pulso", 32'(n_mul), 0);
        verifica("rst_ocioso", 32'(ocupado), 0);
        pede(1'b0, 16'd25, 8'd12);
        espera_pronto(20);
        verifica("rst_depois_resultado", 32'(resultado), 300);
        verifica("rst_depois_erro", 32'(erro), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ula_seq

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Operation sequencer sitting directly upstream of the 8-bit multiplier (multi_8b) and the companion 8-bit divider.
- Accepts one operation request (operands plus opcode), latches the operands and fires a one-cycle `inicio` pulse at the selected unit.
- Waits for that unit's `fim`, captures its result, and presents it with a level `pronto` flag.
- Guards against division by zero and against a unit that never finishes (timeout).

Parameters:
- LARG_A, 16, width of operand A (multiplicando/dividendo) and of `resultado`.
- LARG_B, 8, width of operand B (multiplicador/divisor) and of `resto`.
- TIMEOUT, 128, maximum cycles in ESPERA before the operation is aborted with `erro`.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- inicio  in  1  request strobe; sampled only in OCIOSO or CONCLUI.
- op  in  1  0 = multiply, 1 = divide.
- a  in  LARG_A  operand A.
- b  in  LARG_B  operand B.
- resultado  out  LARG_A  product or quotient.
- resto  out  LARG_B  remainder; 0 for multiply.
- pronto  out  1  result valid; held until next accepted inicio or rst.
- ocupado  out  1  high in DISPARA and ESPERA.
- erro  out  1  div-by-zero or timeout; held like pronto.
- mul_inicio  out  1  one-cycle start pulse to the multiplier.
- mul_multiplicando  out  LARG_A  latched A.
- mul_multiplicador  out  LARG_B  latched B.
- mul_produto  in  LARG_A  multiplier result.
- mul_fim  in  1  multiplier done (level).
- div_inicio  out  1  one-cycle start pulse to the divider.
- div_dividendo  out  LARG_A  latched A.
- div_divisor  out  LARG_B  latched B.
- div_quociente  in  LARG_A  divider quotient.
- div_resto  in  LARG_B  divider remainder.
- div_fim  in  1  divider done (level).

Behaviour:
- Reset: synchronous, active-high on `rst`.
  - State goes to OCIOSO.
  - All outputs are 0, including latched operands, resultado, resto, pronto, erro, ocupado, mul_inicio and div_inicio.
  - rst asserted mid-operation aborts it; no start pulse is issued after the reset edge.
- States: OCIOSO, DISPARA, ESPERA, CONCLUI. All outputs are registered.
- OCIOSO / CONCLUI, on `inicio=1`:
  - Latch op, a and b into the operand registers.
  - Clear pronto and erro.
  - If op=1 and b=0: go directly to CONCLUI with erro=1, pronto=1, resultado=0, resto=0. No div_inicio is issued.
  - Otherwise go to DISPARA.
- DISPARA (exactly 1 cycle):
  - mul_inicio=1 if op=0, or div_inicio=1 if op=1; the other start line stays 0.
  - ocupado=1.
  - Next state is ESPERA; clear the timeout counter.
- ESPERA:
  - ocupado=1; the timeout counter increments every cycle.
  - The selected fim is ignored on the first ESPERA cycle, so a stale fim from the previous operation is never accepted.
  - From the second cycle, selected fim=1 → capture the result into resultado/resto, set pronto=1, go to CONCLUI.
    - Multiply: resto is 0.
    - Divide: resto is div_resto.
  - Counter reaches TIMEOUT with no fim → CONCLUI with erro=1, pronto=1, resultado=0, resto=0.
  - fim and timeout in the same cycle: fim wins, erro=0.
- CONCLUI:
  - resultado, resto, pronto and erro hold until the next accepted inicio.
  - That inicio is processed exactly as in OCIOSO (back-to-back operation allowed).
- Operand outputs are stable from the DISPARA cycle until the next accepted inicio.
- inicio during DISPARA/ESPERA is ignored: no latch, no state change.
- The non-selected unit's fim is ignored at all times.
- Latency, inicio sampled at edge N:
  - Start pulse is visible during cycle N+1.
  - pronto rises one edge after the sampled selected fim.
  - Earliest pronto is at edge N+3.
- Widths: results are taken verbatim from the unit, with no truncation or extension logic.

Decomposition:
- Package ula_pkg:
  - opcode constants OP_MUL=0, OP_DIV=1;
  - state encoding OCIOSO, DISPARA, ESPERA, CONCLUI;
  - default widths LARG_A and LARG_B.
- One natural sub-module, ula_timeout: a counter with clear/enable and an `estouro` output at TIMEOUT. It is instantiated once in ula_seq.

Test Plan:
- Multiply: a=25, b=12, op=0, real multi_8b attached → exactly one mul_inicio pulse, no div_inicio; pronto=1, resultado=300, resto=0, erro=0.
- Back-to-back: issue a=10, b=12, op=0 in CONCLUI right after the previous test → pronto drops the edge after inicio; then resultado=120; the stale mul_fim is not accepted on the first ESPERA cycle.
- Divide: a=200, b=7, op=1 with a behavioural divider → exactly one div_inicio pulse; resultado=28, resto=4, erro=0.
- Divide by zero: a=50, b=0, op=1 → one edge later pronto=1, erro=1, resultado=0; div_inicio never asserts; ocupado never asserts.
- Timeout and busy: multiplier stub with mul_fim stuck at 0.
  - inicio pulses during ESPERA are ignored and the operands stay unchanged.
  - After TIMEOUT=128 ESPERA cycles: erro=1, pronto=1, resultado=0.
- Reset mid-operation: rst pulsed during ESPERA → next edge all outputs are 0 and the state is OCIOSO; a subsequent 25x12 request completes with 300.
